// File: rtl/i_decode_pkg.sv
// Decode-stage shared definitions: opcodes, instruction classes and
// the decoded-field bundle passed from the field cracker to the top.
package i_decode_pkg;

  localparam int DW      = 32;
  localparam int REG_W   = 5;
  localparam int FUNCT_W = 6;
  localparam int SHAMT_W = 5;
  localparam int IMM_W   = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [2:0] {
    CL_ALU_R   = 3'd0,
    CL_ALU_I   = 3'd1,
    CL_LOAD    = 3'd2,
    CL_STORE   = 3'd3,
    CL_BRANCH  = 3'd4,
    CL_JUMP    = 3'd5,
    CL_JR      = 3'd6,
    CL_ILLEGAL = 3'd7
  } cls_e;

  typedef struct packed {
    cls_e               cls;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
    logic               we;
    logic [FUNCT_W-1:0] funct;
    logic [SHAMT_W-1:0] shamt;
    logic [IMM_W-1:0]   imm;
  } fields_t;

  function automatic logic [IMM_W-1:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/i_decode_fields.sv
// Combinational instruction cracker: class, register fields,
// immediate and branch/jump target for one instruction.
module i_decode_fields
  import i_decode_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic [DW-1:0]            instruction,
  input  logic [ADDRESS_WIDTH-1:0] pc,
  output fields_t                  fields,
  output logic [ADDRESS_WIDTH-1:0] target
);

  logic [5:0]               op;
  logic [5:0]               fn;
  logic [ADDRESS_WIDTH-1:0] pc1;
  logic [IMM_W-1:0]         simm;

  assign op   = instruction[31:26];
  assign fn   = instruction[5:0];
  assign pc1  = pc + ADDRESS_WIDTH'(1);
  assign simm = sext16(instruction[15:0]);

  always_comb begin
    fields     = '0;
    fields.cls = CL_ILLEGAL;
    fields.rs  = instruction[25:21];
    fields.rt  = instruction[20:16];
    fields.imm = simm;
    target     = '0;
    unique case (1'b1)
      (op == OP_RTYPE): begin
        fields.cls   = (fn == FN_JR) ? CL_JR : CL_ALU_R;
        fields.rd    = instruction[15:11];
        fields.we    = (fn != FN_JR);
        fields.funct = fn;
        fields.shamt = instruction[10:6];
      end
      (op == OP_J), (op == OP_JAL): begin
        fields.cls = CL_JUMP;
        target     = {pc1[ADDRESS_WIDTH-1:26], instruction[25:0]};
        // JAL links PC+1 into r31
        if (op == OP_JAL) begin
          fields.rd  = 5'd31;
          fields.we  = 1'b1;
          fields.imm = IMM_W'(pc1);
        end
      end
      (op == OP_BEQ), (op == OP_BNE): begin
        fields.cls = CL_BRANCH;
        target     = pc1 + ADDRESS_WIDTH'(simm);
      end
      (op == OP_ADDI), (op == OP_SLTI): begin
        fields.cls = CL_ALU_I;
        fields.rd  = instruction[20:16];
        fields.we  = 1'b1;
      end
      (op == OP_ANDI), (op == OP_ORI): begin
        fields.cls = CL_ALU_I;
        fields.rd  = instruction[20:16];
        fields.we  = 1'b1;
        fields.imm = {16'b0, instruction[15:0]};
      end
      (op == OP_LUI): begin
        fields.cls = CL_ALU_I;
        fields.rd  = instruction[20:16];
        fields.we  = 1'b1;
        fields.imm = {instruction[15:0], 16'b0};
      end
      (op == OP_LW): begin
        fields.cls = CL_LOAD;
        fields.rd  = instruction[20:16];
        fields.we  = 1'b1;
      end
      (op == OP_SW): fields.cls = CL_STORE;
      default: ;
    endcase
  end

endmodule

// File: rtl/i_decode.sv
// Decode stage: pops the fetch FIFO, registers the decoded packet for
// dispatch and merges decode-time jumps with execute redirects.
module i_decode
  import i_decode_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_empty,
  input  logic [DATA_WIDTH-1:0]    fetch_instruction,
  input  logic [ADDRESS_WIDTH-1:0] fetch_pc,
  output logic                     fetch_rd_en,
  output logic                     jump_branch_valid,
  output logic [ADDRESS_WIDTH-1:0] jump_branch_address,
  input  logic                     ex_redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] ex_redirect_address,
  input  logic                     dispatch_ready,
  output logic                     dec_valid,
  output logic [ADDRESS_WIDTH-1:0] dec_pc,
  output logic [2:0]               dec_class,
  output logic [4:0]               dec_rs,
  output logic [4:0]               dec_rt,
  output logic [4:0]               dec_rd,
  output logic                     dec_we,
  output logic [5:0]               dec_funct,
  output logic [4:0]               dec_shamt,
  output logic [31:0]              dec_imm,
  output logic [ADDRESS_WIDTH-1:0] dec_target
);

  typedef enum logic {RUN, REDIRECT} state_e;

  state_e                   state;
  state_e                   next_state;
  fields_t                  fld;
  fields_t                  pkt;
  logic [ADDRESS_WIDTH-1:0] fld_target;
  logic                     jump_hit;
  logic                     pulse_next;
  logic [ADDRESS_WIDTH-1:0] address_next;

  i_decode_fields #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_fields (
    .instruction(fetch_instruction),
    .pc         (fetch_pc),
    .fields     (fld),
    .target     (fld_target)
  );

  assign fetch_rd_en = (state == RUN) && !fetch_empty
                    && (!dec_valid || dispatch_ready)
                    && !ex_redirect_valid;
  assign jump_hit = fetch_rd_en && (fld.cls == CL_JUMP);

  always_comb begin
    next_state   = state;
    pulse_next   = 1'b0;
    address_next = jump_branch_address;
    unique case (1'b1)
      ex_redirect_valid: begin
        next_state   = REDIRECT;
        pulse_next   = 1'b1;
        address_next = ex_redirect_address;
      end
      jump_hit: begin
        next_state   = REDIRECT;
        pulse_next   = 1'b1;
        address_next = fld_target;
      end
      default: next_state = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= RUN;
      jump_branch_valid   <= 1'b0;
      jump_branch_address <= '0;
      dec_valid           <= 1'b0;
      pkt                 <= '0;
      dec_pc              <= '0;
      dec_target          <= '0;
    end else begin
      state               <= next_state;
      jump_branch_valid   <= pulse_next;
      jump_branch_address <= address_next;
      if (ex_redirect_valid) begin
        dec_valid <= 1'b0;
      end else if (fetch_rd_en) begin
        dec_valid  <= 1'b1;
        pkt        <= fld;
        dec_pc     <= fetch_pc;
        dec_target <= fld_target;
      end else if (dispatch_ready) begin
        dec_valid <= 1'b0;
      end
    end
  end

  assign dec_class = pkt.cls;
  assign dec_rs    = pkt.rs;
  assign dec_rt    = pkt.rt;
  assign dec_rd    = pkt.rd;
  assign dec_we    = pkt.we;
  assign dec_funct = pkt.funct;
  assign dec_shamt = pkt.shamt;
  assign dec_imm   = pkt.imm;

endmodule

// File: tb/tb_i_decode.sv
// Randomized bench for i_decode: a fetch-side program model feeds the
// DUT and a transaction scoreboard predicts every dispatched packet.
module tb_i_decode;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  cls;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        we;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] imm;
    logic [31:0] target;
  } pkt_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_empty;
  logic [31:0] fetch_instruction;
  logic [31:0] fetch_pc;
  logic        fetch_rd_en;
  logic        jump_branch_valid;
  logic [31:0] jump_branch_address;
  logic        ex_redirect_valid;
  logic [31:0] ex_redirect_address;
  logic        dispatch_ready;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [2:0]  dec_class;
  logic [4:0]  dec_rs;
  logic [4:0]  dec_rt;
  logic [4:0]  dec_rd;
  logic        dec_we;
  logic [5:0]  dec_funct;
  logic [4:0]  dec_shamt;
  logic [31:0] dec_imm;
  logic [31:0] dec_target;

  i_decode #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) dut (
    .clk                (clk),
    .reset              (reset),
    .fetch_empty        (fetch_empty),
    .fetch_instruction  (fetch_instruction),
    .fetch_pc           (fetch_pc),
    .fetch_rd_en        (fetch_rd_en),
    .jump_branch_valid  (jump_branch_valid),
    .jump_branch_address(jump_branch_address),
    .ex_redirect_valid  (ex_redirect_valid),
    .ex_redirect_address(ex_redirect_address),
    .dispatch_ready     (dispatch_ready),
    .dec_valid          (dec_valid),
    .dec_pc             (dec_pc),
    .dec_class          (dec_class),
    .dec_rs             (dec_rs),
    .dec_rt             (dec_rt),
    .dec_rd             (dec_rd),
    .dec_we             (dec_we),
    .dec_funct          (dec_funct),
    .dec_shamt          (dec_shamt),
    .dec_imm            (dec_imm),
    .dec_target         (dec_target)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] prog [64];
  logic [31:0] fpc;
  pkt_t        exp_q [$];
  logic        exp_jbv;
  logic [31:0] exp_jaddr;
  logic        blocked;
  logic        exp_rd_en;
  bit          found;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic pkt_t ref_decode(input logic [31:0] ins,
                                      input logic [31:0] pc);
    pkt_t p;
    logic [31:0] nxt = pc + 32'd1;
    logic [31:0] se  = {{16{ins[15]}}, ins[15:0]};
    p = '0;
    p.pc = pc;
    p.rs = ins[25:21];
    p.rt = ins[20:16];
    p.imm = se;
    p.cls = 3'd7;
    case (ins[31:26])
      6'h00: begin
        p.cls   = (ins[5:0] == 6'h08) ? 3'd6 : 3'd0;
        p.we    = (ins[5:0] != 6'h08);
        p.rd    = ins[15:11];
        p.funct = ins[5:0];
        p.shamt = ins[10:6];
      end
      6'h02: begin p.cls = 3'd5; p.target = {nxt[31:26], ins[25:0]}; end
      6'h03: begin
        p.cls = 3'd5; p.target = {nxt[31:26], ins[25:0]};
        p.rd = 5'd31; p.we = 1'b1; p.imm = nxt;
      end
      6'h04, 6'h05: begin p.cls = 3'd4; p.target = nxt + se; end
      6'h08, 6'h0A: begin p.cls = 3'd1; p.rd = p.rt; p.we = 1'b1; end
      6'h0C, 6'h0D: begin
        p.cls = 3'd1; p.rd = p.rt; p.we = 1'b1; p.imm = {16'h0, ins[15:0]};
      end
      6'h0F: begin
        p.cls = 3'd1; p.rd = p.rt; p.we = 1'b1; p.imm = {ins[15:0], 16'h0};
      end
      6'h23: begin p.cls = 3'd2; p.rd = p.rt; p.we = 1'b1; end
      6'h2B: p.cls = 3'd3;
      default: ;
    endcase
    return p;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w = $urandom;
    logic [5:0] op;
    case ($urandom_range(0, 13))
      0, 1: op = 6'h00;
      2: op = 6'h02;  3: op = 6'h03;  4: op = 6'h04;  5: op = 6'h05;
      6: op = 6'h08;  7: op = 6'h0A;  8: op = 6'h0C;  9: op = 6'h0D;
      10: op = 6'h0F; 11: op = 6'h23; 12: op = 6'h2B;
      default: op = 6'($urandom);
    endcase
    w[31:26] = op;
    if (op == 6'h00 && w[7]) w[5:0] = 6'h08;
    return w;
  endfunction

  function automatic pkt_t observed();
    pkt_t o;
    o = '{dec_pc, dec_class, dec_rs, dec_rt, dec_rd, dec_we,
          dec_funct, dec_shamt, dec_imm, dec_target};
    return o;
  endfunction

  task automatic drive(input int cyc);
    logic [31:0] head = prog[fpc[5:0]];
    dispatch_ready = ($urandom_range(0, 3) != 0);
    fetch_empty    = ($urandom_range(0, 3) == 0);
    ex_redirect_valid = (cyc > 40) && (($urandom_range(0, 24) == 0)
      || (!fetch_empty && head[31:27] == 5'b00001
          && $urandom_range(0, 2) == 0));
    ex_redirect_address = $urandom;
    fetch_pc = fpc;
    fetch_instruction = fetch_empty ? $urandom : head;
  endtask

  task automatic check_cycle();
    exp_rd_en = !blocked && !fetch_empty
             && (exp_q.size() == 0 || dispatch_ready) && !ex_redirect_valid;
    check("rd_en", 128'(fetch_rd_en), 128'(exp_rd_en));
    check("valid", 128'(dec_valid), 128'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("packet", 128'(observed()), 128'(exp_q[0]));
    check("jb_valid", 128'(jump_branch_valid), 128'(exp_jbv));
    check("jb_addr", 128'(jump_branch_address), 128'(exp_jaddr));
  endtask

  task automatic update_model();
    pkt_t p;
    logic nj = 1'b0;
    logic nb = 1'b0;
    if (exp_jbv) fpc = exp_jaddr;
    else if (exp_rd_en) fpc = fpc + 32'd1;
    if (exp_q.size() != 0 && dispatch_ready) void'(exp_q.pop_front());
    if (ex_redirect_valid) begin
      exp_q.delete();
      nj = 1'b1; nb = 1'b1;
      exp_jaddr = ex_redirect_address;
    end else if (exp_rd_en) begin
      p = ref_decode(fetch_instruction, fetch_pc);
      exp_q.push_back(p);
      if (p.cls == 3'd5) begin
        nj = 1'b1; nb = 1'b1;
        exp_jaddr = p.target;
      end
    end
    exp_jbv = nj;
    blocked = nb;
  endtask

  initial begin
    foreach (prog[i]) prog[i] = rnd_instr();
    prog[4]  = 32'h2001FFFF;
    prog[5]  = 32'h0800000D;
    prog[13] = 32'h34028000;
    prog[14] = 32'h3C031234;
    prog[15] = 32'h00221820;
    prog[16] = 32'h1000FFFE;
    prog[17] = 32'h0C000020;
    prog[32] = 32'h0C000028;
    reset = 1'b1;
    fetch_empty = 1'b1;
    fetch_instruction = '0;
    fetch_pc = '0;
    ex_redirect_valid = 1'b0;
    ex_redirect_address = '0;
    dispatch_ready = 1'b1;
    @(negedge clk);
    check("rst_valid", 128'(dec_valid), 128'(0));
    check("rst_packet", 128'(observed()), 128'(0));
    check("rst_jb", 128'({jump_branch_valid, jump_branch_address}), 128'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    exp_jbv = 1'b0; exp_jaddr = '0; blocked = 1'b0; fpc = 32'h4;
    drive(0);
    for (int cyc = 1; cyc <= 4000; cyc++) begin
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      update_model();
      #1 drive(cyc);
    end
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge clk);
      check_cycle();
      if (blocked) begin
        found = 1'b1;
      end else begin
        @(posedge clk);
        update_model();
        #1 drive(5000);
      end
    end
    check("redirect_seen", 128'(found), 128'(1));
    #1 reset = 1'b1;
    #1;
    check("mid_rst_valid", 128'(dec_valid), 128'(0));
    check("mid_rst_packet", 128'(observed()), 128'(0));
    check("mid_rst_jb",
          128'({jump_branch_valid, jump_branch_address}), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i_decode.md
Name: i_decode

Overview:
- Decode stage directly downstream of the instruction-fetch FIFO.
- Pops one instruction per cycle from the fetch queue and cracks it into fields and class.
- Sends the decoded packet to dispatch through a one-entry skid-free output register with a valid/ready handshake.
- Resolves unconditional J/JAL at decode. Arbitrates those with execute-stage redirects into the single jump/branch port of fetch.

Parameters:
- DATA_WIDTH, 32, instruction width (fixed MIPS-style encoding; must be 32).
- ADDRESS_WIDTH, 32, PC width; PCs are word addresses (PC+1 = next instruction).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_empty  in  1  fetch FIFO empty.
- fetch_instruction  in  DATA_WIDTH  head-of-FIFO instruction (show-ahead, valid when !fetch_empty).
- fetch_pc  in  ADDRESS_WIDTH  PC of head instruction.
- fetch_rd_en  out  1  pop head of FIFO at this edge (to fetch Read_enable).
- jump_branch_valid  out  1  redirect pulse to fetch.
- jump_branch_address  out  ADDRESS_WIDTH  redirect target to fetch.
- ex_redirect_valid  in  1  execute-stage redirect (mispredict/JR).
- ex_redirect_address  in  ADDRESS_WIDTH  execute redirect target.
- dispatch_ready  in  1  dispatch accepts the packet this cycle.
- dec_valid  out  1  packet valid.
- dec_pc  out  ADDRESS_WIDTH  packet PC.
- dec_class  out  3  ALU_R=0, ALU_I=1, LOAD=2, STORE=3, BRANCH=4, JUMP=5, JR=6, ILLEGAL=7.
- dec_rs, dec_rt, dec_rd  out  5 each  register fields; dec_rd = 31 for JAL, rt for I-type writers.
- dec_we  out  1  instruction writes a register.
- dec_funct  out  6  funct field (R-type), else 0.
- dec_shamt  out  5  shift amount.
- dec_imm  out  32  extended immediate.
- dec_target  out  ADDRESS_WIDTH  branch/jump target, or link PC+1 for JAL in dec_imm.

Behaviour:
- Reset (async): dec_valid=0, all dec_* fields 0, jump_branch_valid=0, jump_branch_address=0, FSM=RUN.
- fetch_rd_en is combinational: RUN & !fetch_empty & (!dec_valid | dispatch_ready) & !ex_redirect_valid.
- Accept at an edge where fetch_rd_en=1: output register loads the decoded head and dec_valid=1. Decode latency is 1 cycle.
- At an edge where dispatch_ready & dec_valid & no accept: dec_valid<=0.
- Decode rules:
  - Opcode 0x00 gives ALU_R, or JR if funct=0x08.
  - 0x02 J and 0x03 JAL give JUMP.
  - 0x04/0x05 give BRANCH.
  - 0x08/0x0A/0x0C/0x0D/0x0F give ALU_I.
  - 0x23 gives LOAD; 0x2B gives STORE; anything else gives ILLEGAL (still dispatched, dec_we=0).
- Immediates: ANDI/ORI zero-extend; LUI is imm<<16; all others sign-extend.
- Targets:
  - BRANCH: dec_target = PC+1+sext(imm), truncated to ADDRESS_WIDTH.
  - JUMP: dec_target = {(PC+1)[AW-1:26], instr[25:0]}.
  - JAL: dec_imm = PC+1.
- FSM has states RUN and REDIRECT.
  - RUN: accepting a JUMP sets jump_branch_valid<=1 and jump_branch_address<=jump target, then goes to REDIRECT.
  - REDIRECT: one cycle, no accept (fetch is flushing). jump_branch_valid<=0 at exit, back to RUN.
  - jump_branch_valid is a registered single-cycle pulse.
- ex_redirect_valid has absolute priority in any state:
  - Next edge: dec_valid<=0, no accept, jump_branch_valid<=1, jump_branch_address<=ex_redirect_address, FSM<=REDIRECT.
  - Any decode jump in the same cycle is discarded.
- Stall: dec_valid & !dispatch_ready holds all dec_* stable and holds fetch_rd_en=0.
- No delay slot. Instructions after a JUMP are never accepted before the redirect.
- Reset mid-operation clears the packet and any pending redirect immediately.

Decomposition:
- Package i_decode_pkg holds:
  - opcode/funct localparams;
  - class encodings;
  - the decoded-packet field widths.
- One combinational sub-module i_decode_fields takes (instruction, pc) and produces class, fields, we, imm, target. The top holds the FSM, handshake and output register.

Test Plan:
- Reset then FIFO holds ADDI r1,r0,-1 (0x2001FFFF) at PC 0x4, dispatch_ready=1 → next cycle dec_valid=1, class=1, dec_rd=1, dec_imm=0xFFFFFFFF, dec_we=1.
- ORI 0x3402_8000 → dec_imm=0x00008000. LUI 0x3C03_1234 → dec_imm=0x12340000.
- J 0x0800000D at PC 0x5 → jump_branch_valid pulses 1 cycle with address 0x0D. fetch_rd_en=0 in the REDIRECT cycle. The instruction at PC 0x6 is never dispatched.
- BEQ with imm=0xFFFE at PC 0x10 → class=4, dec_target=0x0F. JAL at PC 0x20 → dec_rd=31, dec_imm=0x21.
- dispatch_ready=0 for 3 cycles with the FIFO non-empty → dec_* held constant, fetch_rd_en=0, and no instruction lost or duplicated after release.
- ex_redirect_valid with address 0x09 in the same cycle a J is accepted → jump_branch_address=0x09, dec_valid=0; async reset asserted mid-REDIRECT → all outputs 0 immediately.
